// File: rtl/stopwatch_cu_if.sv
// Button inputs and control outputs exchanged between the board-side driver and
// the stopwatch control unit.
interface stopwatch_cu_if;
    logic       i_btn_run;
    logic       i_btn_clear;
    logic       i_btn_mode;
    logic       o_run_stop;
    logic       o_clear;
    logic       o_option;
    logic [1:0] o_state;

    modport master (
        output i_btn_run, i_btn_clear, i_btn_mode,
        input  o_run_stop, o_clear, o_option, o_state
    );

    modport slave (
        input  i_btn_run, i_btn_clear, i_btn_mode,
        output o_run_stop, o_clear, o_option, o_state
    );
endinterface

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: synchronizes and debounces three push buttons and
// runs a Moore FSM that drives the datapath run/clear/option controls.
module stopwatch_cu #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic          clk,
    input  logic          rst,
    stopwatch_cu_if.slave bus
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP    = 2'b00,
        ST_RUN     = 2'b01,
        ST_CLEAR   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // Channel order: 0 = run, 1 = clear, 2 = mode
    logic [2:0] btn_raw;
    logic [2:0] btn_edge;

    assign btn_raw = {bus.i_btn_mode, bus.i_btn_clear, bus.i_btn_run};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic          sync1_q;
            logic          sync_q;
            logic          db_q;
            logic          db_prev_q;
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q   <= 1'b0;
                    sync_q    <= 1'b0;
                    db_q      <= 1'b0;
                    db_prev_q <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= btn_raw[gi];
                    sync_q    <= sync1_q;
                    db_prev_q <= db_q;
                    // Any return to the accepted level restarts the stability count
                    if (sync_q == db_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        db_q  <= sync_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign btn_edge[gi] = db_q & ~db_prev_q;
        end
    endgenerate

    state_t state_q, state_d;
    logic   option_q, option_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_STOP;
            option_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            option_q <= option_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        option_d = option_q ^ btn_edge[2];
        case (state_q)
            // Run takes priority over a clear arriving in the same cycle
            ST_STOP: begin
                if (btn_edge[0]) begin
                    state_d = ST_RUN;
                end else if (btn_edge[1]) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (btn_edge[0]) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    always_comb begin
        bus.o_run_stop = 1'b0;
        bus.o_clear    = 1'b0;
        bus.o_run_stop = (state_q == ST_RUN);
        bus.o_clear    = (state_q == ST_CLEAR);
    end

    assign bus.o_option = option_q;
    assign bus.o_state  = state_q;
endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu with a 4-cycle debounce; each check compares a
// DUT output against a hand-derived value.
module tb_stopwatch_cu;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   clr_seen;
    logic opt_exp;

    stopwatch_cu_if bus ();

    stopwatch_cu #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("ok   %-20s observed %0d", tag, obs);
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic run, input logic clr, input logic mode);
        bus.i_btn_run   = run;
        bus.i_btn_clear = clr;
        bus.i_btn_mode  = mode;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0);

        // Reset asserted between clock edges with run and clear held
        #2;
        rst = 1'b1;
        set_btn(1'b1, 1'b1, 1'b0);
        #1;
        check("rst_async_run", {1'b0, bus.o_run_stop}, 2'd0);
        check("rst_async_clear", {1'b0, bus.o_clear}, 2'd0);
        check("rst_async_option", {1'b0, bus.o_option}, 2'd0);
        check("rst_async_state", bus.o_state, 2'b00);
        step(3);
        check("rst_hold_state", bus.o_state, 2'b00);
        rst = 1'b0;
        // Held buttons debounce afresh: run wins over clear at edge 6
        step(6);
        check("post_rst_e5_state", bus.o_state, 2'b00);
        step(1);
        check("post_rst_e6_state", bus.o_state, 2'b01);
        check("post_rst_e6_clear", {1'b0, bus.o_clear}, 2'd0);
        clr_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (bus.o_clear) clr_seen++;
        end
        check("simul_no_clear", 2'(clr_seen), 2'd0);
        check("simul_hold_state", bus.o_state, 2'b01);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);

        // Run toggle: long hold gives a single toggle
        set_btn(1'b1, 1'b0, 1'b0);
        step(6);
        check("run1_e5_state", bus.o_state, 2'b01);
        step(1);
        check("run1_e6_run_stop", {1'b0, bus.o_run_stop}, 2'd0);
        step(3);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);
        check("run1_single_toggle", bus.o_state, 2'b00);
        set_btn(1'b1, 1'b0, 1'b0);
        step(6);
        check("run2_e5_run_stop", {1'b0, bus.o_run_stop}, 2'd0);
        step(1);
        check("run2_e6_run_stop", {1'b0, bus.o_run_stop}, 2'd1);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);
        set_btn(1'b1, 1'b0, 1'b0);
        step(7);
        check("run3_e6_state", bus.o_state, 2'b00);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);

        // Glitch rejection: 2- and 3-cycle pulses dropped, 4-cycle accepted
        set_btn(1'b1, 1'b0, 1'b0);
        step(2);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);
        check("glitch2_state", bus.o_state, 2'b00);
        set_btn(1'b1, 1'b0, 1'b0);
        step(3);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);
        check("glitch3_run_stop", {1'b0, bus.o_run_stop}, 2'd0);
        set_btn(1'b1, 1'b0, 1'b0);
        step(4);
        set_btn(1'b0, 1'b0, 1'b0);
        step(2);
        check("pulse4_e5_state", bus.o_state, 2'b00);
        step(1);
        check("pulse4_e6_state", bus.o_state, 2'b01);
        step(8);

        // Clear is ignored while running
        set_btn(1'b0, 1'b1, 1'b0);
        clr_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (bus.o_clear) clr_seen++;
        end
        check("clear_in_run_pulse", 2'(clr_seen), 2'd0);
        check("clear_in_run_state", bus.o_state, 2'b01);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);
        set_btn(1'b1, 1'b0, 1'b0);
        step(7);
        check("stop_again_state", bus.o_state, 2'b00);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);

        // Clear in STOP: one-cycle pulse, states 00 -> 10 -> 00
        set_btn(1'b0, 1'b1, 1'b0);
        step(6);
        check("clear_e5_state", bus.o_state, 2'b00);
        check("clear_e5_pulse", {1'b0, bus.o_clear}, 2'd0);
        step(1);
        check("clear_e6_state", bus.o_state, 2'b10);
        check("clear_e6_pulse", {1'b0, bus.o_clear}, 2'd1);
        step(1);
        check("clear_e7_state", bus.o_state, 2'b00);
        check("clear_e7_pulse", {1'b0, bus.o_clear}, 2'd0);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);
        check("clear_release_state", bus.o_state, 2'b00);

        // Mode together with run: option and state change on the same edge
        set_btn(1'b1, 1'b0, 1'b1);
        step(6);
        check("run_mode_e5_option", {1'b0, bus.o_option}, 2'd0);
        check("run_mode_e5_state", bus.o_state, 2'b00);
        step(1);
        check("run_mode_e6_option", {1'b0, bus.o_option}, 2'd1);
        check("run_mode_e6_state", bus.o_state, 2'b01);
        set_btn(1'b0, 1'b0, 1'b0);
        step(8);

        // Four further mode presses: option 0, 1, 0, 1
        opt_exp = 1'b1;
        for (int p = 0; p < 4; p++) begin
            opt_exp = ~opt_exp;
            set_btn(1'b0, 1'b0, 1'b1);
            step(7);
            check($sformatf("mode_press%0d_option", p), {1'b0, bus.o_option}, {1'b0, opt_exp});
            set_btn(1'b0, 1'b0, 1'b0);
            step(8);
        end
        check("pre_rst_state", bus.o_state, 2'b01);

        // Mid-run reset clears outputs without a clock edge
        rst = 1'b1;
        #1;
        check("midrun_rst_run_stop", {1'b0, bus.o_run_stop}, 2'd0);
        check("midrun_rst_option", {1'b0, bus.o_option}, 2'd0);
        check("midrun_rst_state", bus.o_state, 2'b00);
        step(2);
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/stopwatch_cu.md
# stopwatch_cu

Control unit for the stopwatch datapath. It takes three raw push-button inputs (run/stop, clear, mode), synchronizes and debounces each, and detects press edges. From those edges it drives a Moore state machine that produces the datapath's `run_stop` level, a one-cycle `clear` pulse and the `option` display-select level. It sits between the board buttons and the stopwatch datapath; its outputs connect directly to the datapath's `run_stop`, `clear` and `option` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 100_000 — consecutive clocks a synchronized level must stay stable before it is accepted; minimum 2; set to 4 in simulation.
- `clk`  in  1 — system clock.
- `rst`  in  1 — asynchronous, active-high reset.
- `i_btn_run`  in  1 — raw run/stop button, active-high, asynchronous to `clk`.
- `i_btn_clear`  in  1 — raw clear button, active-high, asynchronous.
- `i_btn_mode`  in  1 — raw mode button, active-high, asynchronous.
- `o_run_stop`  out  1 — 1 while the state is RUN.
- `o_clear`  out  1 — 1 while the state is CLEAR; lasts exactly one cycle per clear.
- `o_option`  out  1 — display select: 0 = msec/sec, 1 = min/hour.
- `o_state`  out  2 — current state encoding, for debug and LEDs.

## Operation
- **Per-button conditioning:** three identical channels, each built as follows.
  - A 2-FF synchronizer produces `sync`.
  - A debounce counter of width `$clog2(DEBOUNCE_CYCLES)` runs alongside a registered level `db`.
  - If `sync == db`, the counter clears to 0.
  - Otherwise, if `counter == DEBOUNCE_CYCLES-1`, then `db <= sync` and the counter clears to 0.
  - Otherwise, the counter increments.
  - A register `db_d` holds the previous `db`. The edge signal is `db & ~db_d`, which is a one-cycle pulse per accepted press.
  - Releases are debounced the same way but generate no pulse.
- **FSM states:**
  - STOP = 2'b00
  - RUN = 2'b01
  - CLEAR = 2'b10
  - 2'b11 is illegal and goes to STOP on the next edge.
- **FSM transitions:**
  - STOP: a run edge goes to RUN; otherwise a clear edge goes to CLEAR; otherwise stay. When run and clear edges arrive in the same cycle, run wins and the clear edge is dropped.
  - RUN: a run edge goes to STOP. Clear edges are ignored while running.
  - CLEAR: goes unconditionally to STOP after one cycle. Run and clear edges in this cycle are dropped.
- **Outputs:** Moore, decoded from the registered state only.
  - `o_run_stop = (state == RUN)`
  - `o_clear = (state == CLEAR)`
  - `o_state = state`
- **Option:** a registered toggle that flips on each mode edge in any state, independent of the FSM and of run/clear activity in the same cycle.
- **Reset values:** state STOP, `o_run_stop` 0, `o_clear` 0, `o_option` 0, `o_state` 2'b00. All synchronizer, `db`, `db_d` and counter registers are 0.
- **Reset while a button is held:** after reset releases, the held level is debounced afresh and produces one edge.

## Timing
- Edge 0 is the first `clk` rising edge that samples a raw button high.
- `sync` is high after edge 1.
- The counter reaches D-1 after edge D, where D = `DEBOUNCE_CYCLES`.
- `db` rises at edge D+1; the edge pulse is high during the cycle following edge D+1.
- The state, and therefore the outputs, update at edge D+2. Total latency from edge 0 to output is D+2 clocks.
- A glitch whose synchronized level lasts fewer than D cycles is rejected: the counter clears on return and `db` is unchanged.
- Holding a button produces exactly one pulse, whatever the hold length. A new pulse requires a debounced release followed by a debounced press.
- `o_clear` is high for exactly one clock, then the state is STOP.
- `rst` takes effect immediately and asynchronously; outputs go to their reset values without waiting for a clock.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset:** assert `rst` with random buttons held, then release -> all outputs 0 and `o_state` = 00. Held buttons yield one edge each 6 edges after the first post-reset sample.
- **Run toggle:** run button held 10 cycles from edge 0 -> `o_run_stop` = 1 after edge 6. Release, then press again -> `o_run_stop` = 0 six edges after the second press sample; one toggle per press.
- **Glitch rejection:** run button pulsed high for 2 cycles, then 3 cycles -> no state change, `o_run_stop` stays 0. A 4-cycle synchronized pulse is accepted.
- **Clear:** in STOP, press clear -> `o_clear` high for exactly 1 cycle at edge 6, `o_state` sequence 00, 10, 00. The same press while in RUN -> no `o_clear`, state stays 01.
- **Simultaneous edges:** in STOP, run and clear pressed on the same edge -> state 01, `o_clear` never asserts. Mode pressed together with run -> `o_option` toggles 0→1 on the same edge the state goes to RUN.
- **Mode toggle and mid-run reset:** three mode presses -> `o_option` sequence 1, 0, 1. Asserting `rst` mid-RUN -> `o_run_stop` 0 and `o_option` 0 immediately.
